// File: rtl/ps2_voice_allocator.sv
// Four-voice allocator driven by raw PS/2 scan-code bytes: decodes F0/E0 prefixes,
// tracks held note keys per slot and steals the oldest slot when all are busy.
module ps2_voice_allocator (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    input  logic        all_off,
    output logic [15:0] voice0_key,
    output logic [15:0] voice1_key,
    output logic [15:0] voice2_key,
    output logic [15:0] voice3_key,
    output logic [3:0]  voice_active,
    output logic        steal_pulse
);
    localparam int NUM_VOICES = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_VOICES-1:0][7:0]     code_q, code_d;
    logic [NUM_VOICES-1:0]          act_q, act_d;
    logic [NUM_VOICES-1:0][1:0]     rank_q, rank_d;
    logic                           steal_q, steal_d;

    logic                           make_ev, brk_ev, note_ok;
    logic [NUM_VOICES-1:0]          hit;
    logic                           has_free;
    logic [1:0]                     free_idx, old_idx, tgt_idx;

    function automatic logic is_note(input logic [7:0] c);
        case (c)
            8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55,
            8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B,
            8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52, 8'h4A:
                is_note = 1'b1;
            default:
                is_note = 1'b0;
        endcase
    endfunction

    assign note_ok = is_note(scan_code);

    // Slot lookup: key match, lowest idle slot, oldest slot (strict > keeps ties on lowest index).
    always_comb begin
        hit      = '0;
        free_idx = 2'd0;
        old_idx  = 2'd0;
        for (int i = 0; i < NUM_VOICES; i++)
            hit[i] = act_q[i] && (code_q[i] == scan_code);
        for (int i = NUM_VOICES - 1; i >= 0; i--)
            if (!act_q[i]) free_idx = i[1:0];
        for (int i = 1; i < NUM_VOICES; i++)
            if (rank_q[i] > rank_q[old_idx]) old_idx = i[1:0];
    end

    assign has_free = ~&act_q;
    assign tgt_idx  = has_free ? free_idx : old_idx;

    // Prefix FSM and event decode.
    always_comb begin
        state_d = state_q;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        if (all_off) begin
            state_d = S_IDLE;
        end else if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code == 8'hE0)      state_d = S_EXT;
                    else if (scan_code == 8'hF0) state_d = S_BREAK;
                    else                         make_ev = 1'b1;
                end
                S_BREAK: begin
                    if (scan_code == 8'hE0)      state_d = S_EXT;
                    else if (scan_code == 8'hF0) state_d = S_BREAK;
                    else begin
                        brk_ev  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (scan_code == 8'hF0)      state_d = S_EXT_BREAK;
                    else if (scan_code == 8'hE0) state_d = S_EXT;
                    else                         state_d = S_IDLE;
                end
                S_EXT_BREAK: begin
                    if (scan_code == 8'hE0)      state_d = S_EXT;
                    else if (scan_code == 8'hF0) state_d = S_EXT_BREAK;
                    else                         state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Slot, age and steal next-state.
    always_comb begin
        code_d  = code_q;
        act_d   = act_q;
        rank_d  = rank_q;
        steal_d = 1'b0;
        if (all_off) begin
            code_d = '0;
            act_d  = '0;
            rank_d = '0;
        end else if (make_ev && note_ok && !(|hit)) begin
            steal_d = !has_free;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i[1:0] == tgt_idx) begin
                    rank_d[i] = 2'd0;
                    act_d[i]  = 1'b1;
                    code_d[i] = scan_code;
                end else if (act_q[i] && rank_q[i] != 2'd3) begin
                    rank_d[i] = rank_q[i] + 2'd1;
                end
            end
        end else if (brk_ev && note_ok) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (hit[i]) begin
                    act_d[i]  = 1'b0;
                    code_d[i] = 8'h00;
                    rank_d[i] = 2'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            act_q   <= '0;
            rank_q  <= '0;
            steal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            act_q   <= act_d;
            rank_q  <= rank_d;
            steal_q <= steal_d;
        end
    end

    // Idle slots hold code 0, so the key word is zero exactly when the slot is idle.
    assign voice0_key   = {8'h00, code_q[0]};
    assign voice1_key   = {8'h00, code_q[1]};
    assign voice2_key   = {8'h00, code_q[2]};
    assign voice3_key   = {8'h00, code_q[3]};
    assign voice_active = act_q;
    assign steal_pulse  = steal_q;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Scoreboard bench: each driven cycle queues the hand-computed post-edge state,
// a monitor pops one entry per edge and compares it with the outputs.
module tb_ps2_voice_allocator;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_valid = 1'b0;
    logic        all_off = 1'b0;
    logic [15:0] voice0_key, voice1_key, voice2_key, voice3_key;
    logic [3:0]  voice_active;
    logic        steal_pulse;

    ps2_voice_allocator dut (
        .clk         (clk),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .all_off     (all_off),
        .voice0_key  (voice0_key),
        .voice1_key  (voice1_key),
        .voice2_key  (voice2_key),
        .voice3_key  (voice3_key),
        .voice_active(voice_active),
        .steal_pulse (steal_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     id;
        logic [3:0][7:0] k;
        logic            st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic chk(input string nm, input int id, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d %s: got %h expected %h", id, nm, got, want);
        end
    endtask

    // One cycle of stimulus plus the expected outputs after the following edge.
    task automatic tx(input bit rs, input bit v, input logic [7:0] c, input bit ao,
                      input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2,
                      input logic [7:0] k3, input bit st);
        exp_t e;
        @(negedge clk);
        reset      = rs;
        scan_valid = v;
        scan_code  = c;
        all_off    = ao;
        e.id = 16'(step_no);
        e.k  = {k3, k2, k1, k0};
        e.st = st;
        q.push_back(e);
        step_no++;
    endtask

    task automatic b(input logic [7:0] c, input logic [7:0] k0, input logic [7:0] k1,
                     input logic [7:0] k2, input logic [7:0] k3, input bit st);
        tx(1'b0, 1'b1, c, 1'b0, k0, k1, k2, k3, st);
    endtask

    task automatic rst();
        tx(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic [3:0] ea;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < 4; i++) ea[i] = (e.k[i] != 8'h00);
            chk("voice0_key", int'(e.id), voice0_key, {8'h00, e.k[0]});
            chk("voice1_key", int'(e.id), voice1_key, {8'h00, e.k[1]});
            chk("voice2_key", int'(e.id), voice2_key, {8'h00, e.k[2]});
            chk("voice3_key", int'(e.id), voice3_key, {8'h00, e.k[3]});
            chk("voice_active", int'(e.id), {12'h000, voice_active}, {12'h000, ea});
            chk("steal_pulse", int'(e.id), {15'h0, steal_pulse}, {15'h0, e.st});
        end
    end

    initial begin
        // Fill, steal oldest, steal again after rank changes.
        rst();
        b(8'h16, 8'h16, 8'h00, 8'h00, 8'h00, 0);
        b(8'h1E, 8'h16, 8'h1E, 8'h00, 8'h00, 0);
        b(8'h26, 8'h16, 8'h1E, 8'h26, 8'h00, 0);
        b(8'h25, 8'h16, 8'h1E, 8'h26, 8'h25, 0);
        b(8'h2E, 8'h2E, 8'h1E, 8'h26, 8'h25, 1);
        tx(0, 0, 8'h00, 0, 8'h2E, 8'h1E, 8'h26, 8'h25, 0);
        b(8'h3D, 8'h2E, 8'h3D, 8'h26, 8'h25, 1);
        b(8'hF0, 8'h2E, 8'h3D, 8'h26, 8'h25, 0);
        b(8'h26, 8'h2E, 8'h3D, 8'h00, 8'h25, 0);
        b(8'h15, 8'h2E, 8'h3D, 8'h15, 8'h25, 0);
        b(8'h1D, 8'h2E, 8'h3D, 8'h15, 8'h1D, 1);
        b(8'h24, 8'h24, 8'h3D, 8'h15, 8'h1D, 1);

        // Saturated-rank tie resolves to the lowest index.
        rst();
        b(8'h16, 8'h16, 8'h00, 8'h00, 8'h00, 0);
        b(8'h1E, 8'h16, 8'h1E, 8'h00, 8'h00, 0);
        b(8'h26, 8'h16, 8'h1E, 8'h26, 8'h00, 0);
        b(8'h25, 8'h16, 8'h1E, 8'h26, 8'h25, 0);
        b(8'hF0, 8'h16, 8'h1E, 8'h26, 8'h25, 0);
        b(8'h25, 8'h16, 8'h1E, 8'h26, 8'h00, 0);
        b(8'h2D, 8'h16, 8'h1E, 8'h26, 8'h2D, 0);
        b(8'h36, 8'h36, 8'h1E, 8'h26, 8'h2D, 1);
        b(8'h3E, 8'h36, 8'h3E, 8'h26, 8'h2D, 1);
        tx(0, 0, 8'h00, 0, 8'h36, 8'h3E, 8'h26, 8'h2D, 0);

        // Typematic repeat, then release.
        rst();
        b(8'h16, 8'h16, 8'h00, 8'h00, 8'h00, 0);
        b(8'h16, 8'h16, 8'h00, 8'h00, 8'h00, 0);
        b(8'h16, 8'h16, 8'h00, 8'h00, 8'h00, 0);
        b(8'hF0, 8'h16, 8'h00, 8'h00, 8'h00, 0);
        b(8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        // Extended prefixes and non-note codes are discarded.
        b(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'h1E, 8'h1E, 8'h00, 8'h00, 8'h00, 0);
        b(8'h77, 8'h1E, 8'h00, 8'h00, 8'h00, 0);

        // Reset mid-prefix: next byte is a make.
        b(8'hF0, 8'h1E, 8'h00, 8'h00, 8'h00, 0);
        rst();
        b(8'h16, 8'h16, 8'h00, 8'h00, 8'h00, 0);

        // all_off beats a simultaneous byte; reset beats all_off and scan_valid.
        b(8'h1E, 8'h16, 8'h1E, 8'h00, 8'h00, 0);
        b(8'h26, 8'h16, 8'h1E, 8'h26, 8'h00, 0);
        b(8'h25, 8'h16, 8'h1E, 8'h26, 8'h25, 0);
        tx(0, 1, 8'h4A, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tx(0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'h16, 8'h16, 8'h00, 8'h00, 8'h00, 0);
        tx(1, 1, 8'h1E, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        // Back-to-back bytes.
        b(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'h1E, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        b(8'h1C, 8'h1C, 8'h00, 8'h00, 8'h00, 0);
        b(8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00, 0);
        b(8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tx(0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        @(negedge clk);
        scan_valid = 1'b0;
        for (int n = 0; n < 20 && q.size() > 0; n++) @(negedge clk);
        chk("scoreboard_drain", step_no, 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
